// File: rtl/stop_it_pkg.sv
// stop_it_pkg: shared state encoding and default timing/score constants for the Stop-It game
package stop_it_pkg;
  typedef enum logic [2:0] {
    WAIT_START,
    STARTING,
    RUNNING,
    CORRECT,
    WRONG,
    WON
  } state_e;
  localparam int HOLD_TICKS = 15;
  localparam int WIN_SCORE  = 9;
  localparam int DIGIT_MAX  = 15;
endpackage

// File: rtl/stop_it_game_ctrl.sv
// stop_it_game_ctrl: Stop-It game FSM, target/digit/score registers and tick counter control
module stop_it_game_ctrl #(
  parameter int HOLD_TICKS = stop_it_pkg::HOLD_TICKS,
  parameter int WIN_SCORE  = stop_it_pkg::WIN_SCORE,
  parameter int DIGIT_MAX  = stop_it_pkg::DIGIT_MAX
) (
  input  logic       clk_4_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [3:0] random_i,
  input  logic [4:0] time_count_i,
  output logic       time_en_o,
  output logic       time_clr_o,
  output logic [3:0] target_o,
  output logic [3:0] digit_o,
  output logic [3:0] score_o,
  output logic       blank_o,
  output logic       success_o,
  output logic       fail_o
);
  import stop_it_pkg::*;
  state_e     state_q, state_d;
  logic [3:0] target_q, target_d, digit_q, digit_d, score_q, score_d;
  logic       hold;
  assign hold = time_count_i == 5'(HOLD_TICKS);
  always_ff @(posedge clk_4_i) begin
    if (rst_i) begin
      state_q  <= WAIT_START;
      target_q <= '0;
      digit_q  <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      digit_q  <= digit_d;
      score_q  <= score_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    digit_d  = digit_q;
    score_d  = score_q;
    case (state_q)
      WAIT_START: if (start_i) begin
        state_d  = STARTING;
        target_d = random_i;
        score_d  = '0;
      end
      STARTING: if (hold) begin
        state_d = RUNNING;
        digit_d = 4'(DIGIT_MAX);
      end
      // stop takes priority over the decrement so the digit freezes on the press
      RUNNING: if (stop_i) begin
        state_d = digit_q == target_q ? CORRECT : WRONG;
        score_d = digit_q == target_q ? score_q + 4'd1 : score_q;
      end else begin
        digit_d = digit_q == 4'd0 ? 4'(DIGIT_MAX) : digit_q - 4'd1;
      end
      CORRECT: if (hold) begin
        state_d  = score_q == 4'(WIN_SCORE) ? WON : STARTING;
        target_d = score_q == 4'(WIN_SCORE) ? target_q : random_i;
      end
      WRONG: if (hold) begin
        state_d  = STARTING;
        target_d = random_i;
      end
      WON: if (start_i) begin
        state_d  = STARTING;
        target_d = random_i;
        score_d  = '0;
      end
      default: state_d = WAIT_START;
    endcase
  end
  assign time_en_o  = state_q inside {STARTING, CORRECT, WRONG};
  assign time_clr_o = state_d != state_q || state_q inside {WAIT_START, WON};
  assign target_o   = target_q;
  assign digit_o    = digit_q;
  assign score_o    = score_q;
  assign blank_o    = state_q == STARTING && time_count_i[0];
  assign success_o  = state_q inside {CORRECT, WON};
  assign fail_o     = state_q == WRONG;
endmodule

// File: doc/stop_it_game_ctrl.md
Name: stop_it_game_ctrl

Overview:
Game controller for the Stop-It game on the Basys3. It runs in the 4 Hz domain and drives the enable and clear of the shared 5-bit tick counter. It reads that counter back to time its display phases. It holds the game state, the target digit, the running down-counted digit and the score, and it judges each stop press.

Parameters:
HOLD_TICKS, 15, counter value at which a timed state (STARTING/CORRECT/WRONG) exits; dwell = HOLD_TICKS+1 cycles
WIN_SCORE, 9, score at which the game enters WON
DIGIT_MAX, 15, reload value of the running digit (4-bit)

Ports:
clk_4_i  in  1  4 Hz game clock; the only clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  single-cycle start pulse (already synchronised/edge-detected)
stop_i  in  1  single-cycle stop pulse (already synchronised/edge-detected)
random_i  in  4  pseudo-random value from LFSR, sampled on target load
time_count_i  in  5  current value of the tick counter
time_en_o  out  1  tick counter enable
time_clr_o  out  1  tick counter clear (active-high; top level inverts for the counter's active-low reset)
target_o  out  4  current target digit
digit_o  out  4  running digit
score_o  out  4  current score
blank_o  out  1  1 = blank target display (blink)
success_o  out  1  high in CORRECT and WON
fail_o  out  1  high in WRONG

Behaviour:
- Interface: one clock (clk_4_i); reset is synchronous and active-high (rst_i).
- Reset (rst_i=1 at edge): state=WAIT_START, target=0, digit=0, score=0. All outputs follow from these.
- States: WAIT_START, STARTING, RUNNING, CORRECT, WRONG, WON.
- time_en_o = 1 in STARTING, CORRECT and WRONG; otherwise 0.
- time_clr_o = 1 when next_state != state, or when in WAIT_START/WON. It is combinational, so the counter reads 0 in the first cycle of every timed state.
- WAIT_START: start_i -> STARTING; target <= random_i; score <= 0.
- STARTING: blank_o = time_count_i[0] (2 Hz blink). time_count_i==HOLD_TICKS -> RUNNING; digit <= DIGIT_MAX.
- RUNNING: digit decrements every cycle; 0 wraps to DIGIT_MAX. stop_i is compared against the registered digit_o in the same cycle.
  - Match -> CORRECT; score <= score+1.
  - Mismatch -> WRONG.
  - The digit freezes on the stop edge.
- CORRECT: on time_count_i==HOLD_TICKS:
  - if score==WIN_SCORE -> WON;
  - else -> STARTING; target <= random_i.
- WRONG: on time_count_i==HOLD_TICKS -> STARTING; target <= random_i; score is kept.
- WON: holds until start_i -> STARTING; score <= 0; target <= random_i.
- blank_o = 0 in all states other than STARTING.
- Simultaneous events:
  - start_i is ignored outside WAIT_START/WON.
  - stop_i is ignored outside RUNNING.
  - If both are high in RUNNING, stop_i is processed.
- Score never exceeds WIN_SCORE (WON is entered on reaching it).
- Reset mid-game: returns to WAIT_START on the same edge regardless of state; time_clr_o=1 the following cycle.
- Illegal state encodings -> WAIT_START.

Decomposition:
- stop_it_pkg holds:
  - state_e enum (6 states, 3-bit encoding);
  - default constants HOLD_TICKS/WIN_SCORE/DIGIT_MAX.
- The blink and timing logic is small; no sub-module is needed. The FSM, target, digit and score registers live in one module with separate next-state always_comb and always_ff blocks.

Test Plan:
- Reset, then idle 5 cycles -> state WAIT_START, score_o=0, time_clr_o=1, time_en_o=0.
- random_i=4'd7, start_i pulse -> next cycle STARTING, target_o=7, counter=0. blank_o toggles each cycle. RUNNING follows 16 cycles later with digit_o=15.
- In RUNNING, pulse stop_i when digit_o=7 with target 7 -> CORRECT, score_o=1, success_o=1 for 16 cycles, then STARTING with new target.
- In RUNNING, pulse stop_i when digit_o=3 with target 7 -> WRONG, fail_o=1, score unchanged. STARTING after 16 cycles.
- Let RUNNING free-run 20 cycles -> digit sequence 15..0,15,14,13,12 (wrap checked).
- Reach score 9 -> WON, success_o=1 held. start_i -> score_o=0, STARTING.
- Assert rst_i in CORRECT, and separately drive stop_i+start_i together in RUNNING -> WAIT_START on that edge; in the second case stop wins.
